fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the 8-bit synchronous FIFO. Pops one byte at a time through the FIFO
//  read port (rd_en/dout/empty) and serialises it as an asynchronous UART frame.
//  Frame: start bit, DATA_W data bits LSB first, optional parity bit, stop bits.
//  Sole reader of the FIFO; runs in the FIFO's clk domain.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  DATA_W        8   byte width; must equal the FIFO data width
//  PARITY_EN     0   1 = insert a parity bit after the data bits
//  PARITY_ODD    0   0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//  STOP_BITS     1   number of stop bits, 1 or 2
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high reset
//  enable      in   1       1 = permit fetching new bytes from the FIFO
//  fifo_empty  in   1       FIFO empty flag
//  fifo_dout   in   DATA_W  FIFO read data; registered, valid the cycle after the rd_en cycle
//  fifo_rd_en  out  1       registered FIFO pop strobe, one cycle per byte
//  tx          out  1       serial line, idles high
//  busy        out  1       1 whenever state != IDLE
//  tx_done     out  1       one-cycle pulse per completed frame
// BEHAVIOUR
//  Reset (sync, priority over everything): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0,
//   baud counter=0, bit index=0. Reset mid-frame aborts the frame; the byte is discarded; tx=1 at next edge.
//  FSM states: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
//   IDLE:   if enable && !fifo_empty -> FETCH.
//   FETCH:  1 cycle; fifo_rd_en=1 in this cycle only -> WAIT.
//   WAIT:   1 cycle; at the closing edge shreg<=fifo_dout -> START.
//   START:  tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA:   tx=shreg[idx], idx 0..DATA_W-1, CLKS_PER_BIT cycles each -> PARITY if PARITY_EN, else STOP.
//   PARITY: tx=^shreg XOR PARITY_ODD for CLKS_PER_BIT cycles -> STOP.
//   STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at the closing edge: if enable && !fifo_empty
//           -> FETCH, else -> IDLE.
//  tx is registered and never glitches. Outside START/DATA/PARITY, tx=1.
//  Latency: if enable && !fifo_empty is sampled at edge E0, fifo_rd_en is high over E0..E1,
//   and tx falls at E2.
//  Frame length: (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   Back-to-back inter-frame gap is exactly 2 cycles (FETCH+WAIT) of tx=1.
//  tx_done: high for exactly the first cycle after the final stop-bit cycle, whether the next state
//   is IDLE or FETCH.
//  Baud counter width: $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit
//   boundary. Bit index width: $clog2(DATA_W)+1.
//  fifo_rd_en is never asserted while fifo_empty=1, and never on two consecutive cycles.
//  enable=0 mid-frame: the current frame completes unchanged; no further fetch.
//  enable toggling while in IDLE has no effect except through the fetch condition.
//  fifo_empty rising after FETCH does not affect the frame already in progress.
// TESTING
//  (CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=0, STOP_BITS=1 unless stated)
//  1 Reset held 3 cycles with FIFO non-empty -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
//  2 FIFO holds 0xA5, enable=1 -> one rd_en pulse; tx=0 at E2; bits (4 cyc each) 0,1,0,1,0,0,1,0,1,1;
//    tx_done pulses at E2+40.
//  3 FIFO holds 0x3C,0xFF,0x00 -> three frames; 2-cycle idle-high gap between frames;
//    decoded bytes match; exactly 3 rd_en pulses; busy drops after the last frame.
//  4 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte 0x07 -> parity bit=1; 8 stop cycles; frame=48 cycles.
//    Repeat with PARITY_ODD=1 -> parity bit=0.
//  5 enable dropped mid-data of 0x55 with a second byte queued -> first frame completes;
//    no rd_en until enable=1 again; then frame 2 starts 2 cycles after the rising enable is sampled.
//  6 Reset asserted during DATA bit 3 -> next edge tx=1, state=IDLE, tx_done stays 0;
//    with FIFO refilled to 0x81 after reset release -> a clean frame for 0x81.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the synchronous byte FIFO and its UART drain stage.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  // master: the reader that issues pops; slave: the FIFO answering them.
  modport master (output fifo_rd_en, input fifo_empty, input fifo_dout);
  modport slave  (input fifo_rd_en, output fifo_empty, output fifo_dout);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the synchronous FIFO and serialises each one as a UART frame
// (start, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned SelW = $clog2(DATA_W);
  localparam int unsigned IdxW = SelW + 1;

  localparam logic [CntW-1:0] CntLast      = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxDataLast  = IdxW'(DATA_W - 1);
  localparam logic [IdxW-1:0] IdxStopLast  = IdxW'(STOP_BITS - 1);
  localparam logic            ParityInvert = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;

  logic bit_end;
  logic fetch_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    bit_end  = (cnt_q == CntLast);
    fetch_ok = enable && !fifo.fifo_empty;

    unique case (state_q)
      StIdle: begin
        if (fetch_ok) state_d = StFetch;
      end
      StFetch: state_d = StWait;
      StWait: begin
        // FIFO data is registered, so it is valid one cycle after the pop.
        shreg_d = fifo.fifo_dout;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IdxDataLast) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          // idx counts stop bits here
          if (idx_q == IdxStopLast) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = fetch_ok ? StFetch : StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level and pop strobe are decoded from the next state so both are registered.
  always_comb begin
    tx_d    = 1'b1;
    rd_en_d = (state_d == StFetch);
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[idx_d[SelW-1:0]];
      StParity: tx_d = (^shreg_d) ^ ParityInvert;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = (state_q != StIdle);
  assign tx_done         = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO models feed three configurations; a line decoder fills a
// scoreboard of received frames that is checked against bytes queued at push time.
module tb_fifo_uart_tx;

  localparam int Cpb   = 4;
  localparam int Frame = (1 + 8 + 0 + 1) * Cpb;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic tx0, busy0, done0;
  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  fifo_uart_tx_if #(.DATA_W(8)) f0 ();
  fifo_uart_tx_if #(.DATA_W(8)) f1 ();
  fifo_uart_tx_if #(.DATA_W(8)) f2 ();

  fifo_uart_tx #(.CLKS_PER_BIT(Cpb), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .fifo(f0), .tx(tx0), .busy(busy0),
    .tx_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(Cpb), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo(f1), .tx(tx1), .busy(busy1),
    .tx_done(done1));

  fifo_uart_tx #(.CLKS_PER_BIT(Cpb), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .fifo(f2), .tx(tx2), .busy(busy2),
    .tx_done(done2));

  always #5 clk = ~clk;

  // Registered-output FIFO models: dout valid the cycle after the pop.
  logic [7:0]  mem0 [16];
  logic [7:0]  mem1 [16];
  logic [7:0]  mem2 [16];
  int unsigned wr0 = 0, wr1 = 0, wr2 = 0;
  int unsigned rd0 = 0, rd1 = 0, rd2 = 0;

  assign f0.fifo_empty = (wr0 == rd0);
  assign f1.fifo_empty = (wr1 == rd1);
  assign f2.fifo_empty = (wr2 == rd2);

  always @(posedge clk) if (f0.fifo_rd_en && (wr0 != rd0)) begin
    f0.fifo_dout <= mem0[rd0[3:0]];
    rd0 <= rd0 + 1;
  end
  always @(posedge clk) if (f1.fifo_rd_en && (wr1 != rd1)) begin
    f1.fifo_dout <= mem1[rd1[3:0]];
    rd1 <= rd1 + 1;
  end
  always @(posedge clk) if (f2.fifo_rd_en && (wr2 != rd2)) begin
    f2.fifo_dout <= mem2[rd2[3:0]];
    rd2 <= rd2 + 1;
  end

  // Line decoder for DUT0: samples each bit in its second cycle; bit 8 of an entry flags a
  // bad start or stop level.
  int         cyc = 0;
  int         rd_cnt0 = 0;
  int         viol0 = 0;
  logic       rd_prev0 = 1'b0;
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_byte = '0;
  logic [8:0] got0 [$];
  int         starts0 [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (f0.fifo_rd_en === 1'b1) begin
      rd_cnt0 <= rd_cnt0 + 1;
      if (f0.fifo_empty || rd_prev0) viol0 <= viol0 + 1;
    end
    rd_prev0 <= (f0.fifo_rd_en === 1'b1);
    if (reset) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (tx0 === 1'b0) begin
        m_act <= 1'b1;
        m_cnt <= 1;
        m_err <= 1'b0;
        starts0.push_back(cyc);
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1 && tx0 !== 1'b0) m_err <= 1'b1;
      if ((m_cnt % Cpb) == 1 && m_cnt / Cpb >= 1 && m_cnt / Cpb <= 8)
        m_byte[3'((m_cnt / Cpb) - 1)] <= tx0;
      if (m_cnt == 9 * Cpb + 1) begin
        got0.push_back({m_err | (tx0 !== 1'b1), m_byte});
        m_act <= 1'b0;
      end
    end
  end

  int         tests = 0;
  int         errs = 0;
  int         gi = 0;
  logic [7:0] exp0 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push0(input logic [7:0] b, input bit track);
    mem0[wr0[3:0]] = b;
    wr0++;
    if (track) exp0.push_back(b);
  endtask

  task automatic wait_start0(input string tag);
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (tx0 !== 1'b0 && b < 60);
    chk(tag, 32'(tx0), 32'(1'b0));
  endtask

  task automatic drain0(input int n);
    for (int i = 0; i < n; i++) begin
      int b;
      logic [8:0] e;
      b = 0;
      while (got0.size() <= gi && b < 200) begin
        @(negedge clk);
        b++;
      end
      e = {1'b0, exp0.pop_front()};
      if (got0.size() > gi) begin
        chk("frame", 32'(got0[gi]), 32'(e));
        gi++;
      end else begin
        chk("frame_timeout", 32'(got0.size()), 32'(gi + 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  fr;
    logic [11:0] fe, fo;
    logic [7:0]  pb;
    int          base, rdb;

    // Reset held with the FIFO non-empty.
    reset  = 1'b1;
    enable = 1'b1;
    push0(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx0), 32'(1'b1));
      chk("rst_rd_en", 32'(f0.fifo_rd_en), 32'(1'b0));
      chk("rst_busy", 32'(busy0), 32'(1'b0));
      chk("rst_done", 32'(done0), 32'(1'b0));
    end
    reset = 1'b0;

    // Single byte, exact latency and bit timing.
    @(negedge clk);
    chk("fetch_rd_en", 32'(f0.fifo_rd_en), 32'(1'b1));
    chk("fetch_busy", 32'(busy0), 32'(1'b1));
    @(negedge clk);
    chk("wait_rd_en", 32'(f0.fifo_rd_en), 32'(1'b0));
    chk("wait_tx", 32'(tx0), 32'(1'b1));
    @(negedge clk);
    chk("e2_tx_low", 32'(tx0), 32'(1'b0));
    fr = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    chk("a5_bit0", 32'(tx0), 32'(fr[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (Cpb) @(negedge clk);
      chk($sformatf("a5_bit%0d", k), 32'(tx0), 32'(fr[k]));
    end
    repeat (2) @(negedge clk);
    chk("a5_done_early", 32'(done0), 32'(1'b0));
    @(negedge clk);
    chk("a5_done", 32'(done0), 32'(1'b1));
    chk("a5_idle", 32'(busy0), 32'(1'b0));
    @(negedge clk);
    chk("a5_done_once", 32'(done0), 32'(1'b0));
    drain0(1);

    // Back-to-back frames.
    base = starts0.size();
    rdb  = rd_cnt0;
    push0(8'h3C, 1'b1);
    push0(8'hFF, 1'b1);
    push0(8'h00, 1'b1);
    drain0(3);
    repeat (4) @(negedge clk);
    chk("b2b_busy_drop", 32'(busy0), 32'(1'b0));
    chk("b2b_rd_pulses", 32'(rd_cnt0 - rdb), 32'd3);
    chk("b2b_gap_1", 32'(starts0[base + 1] - starts0[base]), 32'(Frame + 2));
    chk("b2b_gap_2", 32'(starts0[base + 2] - starts0[base + 1]), 32'(Frame + 2));

    // Parity with two stop bits, even and odd.
    pb = 8'h07;
    mem1[0] = pb;
    wr1 = 1;
    mem2[0] = pb;
    wr2 = 1;
    fe = {2'b11, ^pb, pb, 1'b0};
    fo = {2'b11, ~(^pb), pb, 1'b0};
    repeat (4) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (k != 0) repeat (Cpb) @(negedge clk);
      chk($sformatf("even_bit%0d", k), 32'(tx1), 32'(fe[k]));
      chk($sformatf("odd_bit%0d", k), 32'(tx2), 32'(fo[k]));
    end
    repeat (2) @(negedge clk);
    chk("par_done_early", 32'(done1), 32'(1'b0));
    @(negedge clk);
    chk("even_done_48", 32'(done1), 32'(1'b1));
    chk("odd_done_48", 32'(done2), 32'(1'b1));
    chk("even_idle", 32'(busy1), 32'(1'b0));

    // enable dropped mid-data with a second byte queued.
    rdb = rd_cnt0;
    push0(8'h55, 1'b1);
    push0(8'h66, 1'b1);
    wait_start0("en_start");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    drain0(1);
    repeat (20) @(negedge clk);
    chk("en_no_fetch", 32'(rd_cnt0 - rdb), 32'd1);
    chk("en_idle", 32'(busy0), 32'(1'b0));
    chk("en_line_high", 32'(tx0), 32'(1'b1));
    enable = 1'b1;
    @(negedge clk);
    chk("en_fetch", 32'(f0.fifo_rd_en), 32'(1'b1));
    @(negedge clk);
    chk("en_wait_tx", 32'(tx0), 32'(1'b1));
    @(negedge clk);
    chk("en_start2", 32'(tx0), 32'(1'b0));
    drain0(1);

    // Reset during data bit 3 aborts the frame.
    push0(8'hC3, 1'b0);
    wait_start0("abort_start");
    repeat (4 * Cpb + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx0), 32'(1'b1));
    chk("abort_busy", 32'(busy0), 32'(1'b0));
    chk("abort_done", 32'(done0), 32'(1'b0));
    @(negedge clk);
    chk("abort_done2", 32'(done0), 32'(1'b0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_tx", 32'(tx0), 32'(1'b1));
    chk("abort_no_rd", 32'(f0.fifo_rd_en), 32'(1'b0));
    push0(8'h81, 1'b1);
    drain0(1);
    repeat (5) @(negedge clk);
    chk("rd_en_rules", 32'(viol0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
